mem_ctrl: RTL

- Responder side of the instruction-fetch port (IC_rn/IC_addr → IC_ready/IC_value) and of a load/store data port. Sits between the ICache / load-store unit and the byte-wide external RAM/IO bus.
- Converts each 32-bit word or sub-word request into sequential byte accesses. Assembles read bytes little-endian.
- Arbitrates between the two requesters and returns a one-cycle ready pulse per completed request.

---
 rtl/mem_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store requests onto a byte-wide RAM/IO bus
module mem_ctrl #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IC_rn,
    input  logic [31:0] IC_addr,
    output logic        IC_ready,
    output logic [31:0] IC_value,
    input  logic        LS_en,
    input  logic        LS_wr,
    input  logic [31:0] LS_addr,
    input  logic [1:0]  LS_len,
    input  logic [31:0] LS_wdata,
    output logic        LS_ready,
    output logic [31:0] LS_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t state, state_n;
    logic [1:0]  cnt, cnt_n, last, last_n;
    logic [31:0] base, base_n, wbuf, wbuf_n, rbuf, rbuf_n, rb_cap, mem_a_n, ic_value_n, ls_rdata_n;
    logic [7:0]  dout_n;
    logic        is_ic, is_ic_n, last_grant, last_grant_n, wr_q, wr_q_n;
    logic        ic_ready_n, ls_ready_n, grant_ls, stall;

    // last_grant: 0 = IC, 1 = LS; a stalled IO write or a frozen bus never strobes the RAM
    assign grant_ls = LS_en & (~IC_rn | ~last_grant);
    assign stall    = (base[17:16] == IO_HI) & io_buffer_full;
    assign mem_wr   = wr_q & rdy & ~stall;
    assign rb_cap   = rbuf | ({24'b0, mem_din} << {cnt, 3'b000});

    // next-state and datapath decisions for one bus byte per cycle
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        last_n       = last;
        base_n       = base;
        wbuf_n       = wbuf;
        rbuf_n       = rbuf;
        is_ic_n      = is_ic;
        last_grant_n = last_grant;
        wr_q_n       = wr_q;
        mem_a_n      = mem_a;
        dout_n       = mem_dout;
        ic_ready_n   = 1'b0;
        ls_ready_n   = 1'b0;
        ic_value_n   = IC_value;
        ls_rdata_n   = LS_rdata;
        case (state)
            IDLE: if (IC_rn | LS_en) begin
                is_ic_n      = ~grant_ls;
                last_grant_n = grant_ls;
                base_n       = grant_ls ? LS_addr : IC_addr;
                mem_a_n      = base_n;
                last_n       = grant_ls ? (LS_len == 2'd2 ? 2'd3 : LS_len) : 2'd3;
                wbuf_n       = LS_wdata;
                cnt_n        = 2'd0;
                rbuf_n       = 32'd0;
                wr_q_n       = grant_ls & LS_wr;
                dout_n       = (grant_ls & LS_wr) ? LS_wdata[7:0] : mem_dout;
                state_n      = (grant_ls & LS_wr) ? WRITE : READ;
            end
            READ: begin
                rbuf_n  = rb_cap;
                cnt_n   = cnt + 2'd1;
                mem_a_n = base + {30'b0, cnt} + 32'd1;
                if (cnt == last) begin
                    state_n    = IDLE;
                    cnt_n      = 2'd0;
                    mem_a_n    = 32'd0;
                    ic_ready_n = is_ic;
                    ls_ready_n = ~is_ic;
                    ic_value_n = is_ic ? rb_cap : IC_value;
                    ls_rdata_n = is_ic ? LS_rdata : rb_cap;
                end
            end
            WRITE: if (!stall) begin
                if (cnt == last) begin
                    state_n    = IDLE;
                    cnt_n      = 2'd0;
                    wr_q_n     = 1'b0;
                    mem_a_n    = 32'd0;
                    ls_ready_n = 1'b1;
                end else begin
                    cnt_n   = cnt + 2'd1;
                    mem_a_n = base + {30'b0, cnt} + 32'd1;
                    dout_n  = wbuf[{cnt_n, 3'b000} +: 8];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // register everything; rst wins, rdy low freezes all state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            last       <= 2'd0;
            base       <= 32'd0;
            wbuf       <= 32'd0;
            rbuf       <= 32'd0;
            is_ic      <= 1'b0;
            last_grant <= 1'b0;
            wr_q       <= 1'b0;
            mem_a      <= 32'd0;
            mem_dout   <= 8'd0;
            IC_ready   <= 1'b0;
            LS_ready   <= 1'b0;
            IC_value   <= 32'd0;
            LS_rdata   <= 32'd0;
        end else if (rdy) begin
            state      <= state_n;
            cnt        <= cnt_n;
            last       <= last_n;
            base       <= base_n;
            wbuf       <= wbuf_n;
            rbuf       <= rbuf_n;
            is_ic      <= is_ic_n;
            last_grant <= last_grant_n;
            wr_q       <= wr_q_n;
            mem_a      <= mem_a_n;
            mem_dout   <= dout_n;
            IC_ready   <= ic_ready_n;
            LS_ready   <= ls_ready_n;
            IC_value   <= ic_value_n;
            LS_rdata   <= ls_rdata_n;
        end
    end
endmodule
